// File: rtl/tf32_div_seq.sv
// Sequential TF32 divider: restoring division, one quotient bit per clock,
// RNE rounding with saturate-on-overflow and flush-to-+0 on underflow.
module tf32_div_seq #(
  parameter int QBITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] operand_A,
  input  logic [18:0] operand_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t             state, state_nxt;
  logic               sign_q;
  logic signed [9:0]  exp_diff;
  logic [12:0]        rem;
  logic [10:0]        dvsr;
  logic [QBITS-1:0]   q;
  logic [3:0]         cnt;
  logic [18:0]        res_q;
  logic               dz_q;

  logic               a_zero, b_zero, in_sign;
  logic               ge;
  logic [11:0]        diff;

  assign a_zero  = (operand_A[17:10] == 8'd0);
  assign b_zero  = (operand_B[17:10] == 8'd0);
  assign in_sign = operand_A[18] ^ operand_B[18];

  assign ge   = (rem >= {2'b00, dvsr});
  // rem - dvsr < dvsr whenever ge, so 12 bits hold the difference
  assign diff = rem[11:0] - {1'b0, dvsr};

  // Round stage: normalise the quotient, apply RNE, then range-check
  logic [10:0]        mant;
  logic               g, st;
  logic [11:0]        mant_r;
  logic signed [10:0] e_rnd, e_fin;
  logic [9:0]         mant_fin;
  logic [18:0]        round_res;

  always_comb begin
    mant  = q[12:2];
    g     = q[1];
    st    = q[0] | (rem != 13'd0);
    e_rnd = 11'(exp_diff) + 11'sd126;
    if (q[13]) begin
      mant  = q[13:3];
      g     = q[2];
      st    = (|q[1:0]) | (rem != 13'd0);
      e_rnd = 11'(exp_diff) + 11'sd127;
    end
    mant_r   = {1'b0, mant} + {11'd0, g & (mant[0] | st)};
    e_fin    = e_rnd;
    mant_fin = mant_r[9:0];
    if (mant_r[11]) begin
      e_fin    = e_rnd + 11'sd1;
      mant_fin = 10'd0;
    end
    if (e_fin > 11'sd254)
      round_res = {sign_q, 8'd254, 10'h3FF};
    else if (e_fin < 11'sd1)
      round_res = 19'h00000;
    else
      round_res = {sign_q, e_fin[7:0], mant_fin};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (a_zero || b_zero) ? DONE : DIV;
      DIV:   if (cnt == 4'd0) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q   <= 1'b0;
      exp_diff <= '0;
      rem      <= '0;
      dvsr     <= '0;
      q        <= '0;
      cnt      <= '0;
      res_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q   <= in_sign;
          exp_diff <= $signed({2'b00, operand_A[17:10]}) - $signed({2'b00, operand_B[17:10]});
          rem      <= {2'b00, 1'b1, operand_A[9:0]};
          dvsr     <= {1'b1, operand_B[9:0]};
          q        <= '0;
          cnt      <= 4'd13;
          // Zero divisor wins over zero dividend
          if (b_zero) begin
            res_q <= {in_sign, 8'd254, 10'h3FF};
            dz_q  <= 1'b1;
          end else if (a_zero) begin
            res_q <= 19'h00000;
            dz_q  <= 1'b0;
          end
        end
        DIV: begin
          q   <= {q[QBITS-2:0], ge};
          rem <= ge ? {diff, 1'b0} : {rem[11:0], 1'b0};
          cnt <= cnt - 4'd1;
        end
        ROUND: res_q <= round_res;
        DONE:  if (out_ready) dz_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign result      = res_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_tf32_div_seq.sv
// Bench for tf32_div_seq: directed vector table, handshake/reset sequences,
// and random operands against an exact rational-division reference.
module tb_tf32_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [18:0] operand_A, operand_B;
  logic        out_valid, out_ready;
  logic [18:0] result;
  logic        div_by_zero;

  int n_vec = 0;
  int n_bad = 0;

  tf32_div_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand_A(operand_A), .operand_B(operand_B),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] a;
    logic [18:0] b;
    logic [18:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Exact quotient of the significands with 40 extra fraction bits, then RNE.
  function automatic logic [18:0] ref_div(input logic [18:0] a, input logic [18:0] b);
    logic s;
    int ea, eb, lead, sh, e;
    longint unsigned num, den, qq, rm, m, rb, half;
    s  = a[18] ^ b[18];
    ea = int'(a[17:10]);
    eb = int'(b[17:10]);
    if (eb == 0) return {s, 8'd254, 10'h3FF};
    if (ea == 0) return 19'h00000;
    num  = (64'd1024 + 64'(a[9:0])) << 40;
    den  = 64'd1024 + 64'(b[9:0]);
    qq   = num / den;
    rm   = num % den;
    lead = qq[40] ? 40 : 39;
    sh   = lead - 10;
    m    = qq >> sh;
    rb   = qq & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rb > half || (rb == half && (rm != 0 || m[0]))) m = m + 64'd1;
    e = ea - eb + 127 + (lead - 40);
    if (m == 64'd2048) begin
      m = 64'd1024;
      e = e + 1;
    end
    if (e > 254) return {s, 8'd254, 10'h3FF};
    if (e < 1)   return 19'h00000;
    return {s, 8'(e), m[9:0]};
  endfunction

  // Starts at a negedge; lat counts edges from the accepting edge to out_valid.
  task automatic run_op(input logic [18:0] a, input logic [18:0] b,
                        output logic [18:0] r, output logic dz, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL in_ready timeout: got 0, wanted 1");
    end
    in_valid  = 1'b1;
    operand_A = a;
    operand_B = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid  = 1'b0;
    operand_A = 19'($urandom);
    operand_B = 19'($urandom);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r  = result;
    dz = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t        tbl[9];
    logic [18:0] r, a, b;
    logic        dz;
    int          lat;

    tbl[0] = '{19'h1FC00, 19'h20200, 19'h1F555, 1'b0, 16};
    tbl[1] = '{19'h20600, 19'h20000, 19'h20200, 1'b0, 16};
    tbl[2] = '{19'h5FC00, 19'h20200, 19'h5F555, 1'b0, 16};
    tbl[3] = '{19'h3FBFF, 19'h00400, 19'h3FBFF, 1'b0, 16};
    tbl[4] = '{19'h00400, 19'h20000, 19'h00000, 1'b0, 16};
    tbl[5] = '{19'h7FBFF, 19'h00400, 19'h7FBFF, 1'b0, 16};
    tbl[6] = '{19'h1FC00, 19'h40000, 19'h7FBFF, 1'b1, 1};
    tbl[7] = '{19'h40000, 19'h20000, 19'h00000, 1'b0, 1};
    tbl[8] = '{19'h20000, 19'h20200, 19'h1F955, 1'b0, 16};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operand_A = '0; operand_B = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, r, dz, lat);
      chk($sformatf("vec%0d result", i), 32'(r), 32'(tbl[i].r));
      chk($sformatf("vec%0d div_by_zero", i), 32'(dz), 32'(tbl[i].dz));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Backpressure: hold result in DONE while a new operation waits
    in_valid = 1'b1; operand_A = 19'h1FC00; operand_B = 19'h20200;
    @(posedge clk);
    @(negedge clk);
    operand_A = 19'h20600; operand_B = 19'h20000;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("bp out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp result stable", 32'(result), 32'h1F555);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp in_ready after release", 32'(in_ready), 32'd1);
    chk("bp out_valid after release", 32'(out_valid), 32'd0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("bp queued latency", 32'(lat), 32'd16);
    chk("bp queued result", 32'(result), 32'h20200);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the seventh DIV cycle
    in_valid = 1'b1; operand_A = 19'h1FC00; operand_B = 19'h20200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(19'h20000, 19'h20200, r, dz, lat);
    chk("post-reset result", 32'(r), 32'h1F955);
    chk("post-reset latency", 32'(lat), 32'd16);

    // Random normal operands: half over the full range, half near unity
    for (int i = 0; i < 2000; i++) begin
      a[18] = 1'($urandom);
      b[18] = 1'($urandom);
      a[9:0] = 10'($urandom);
      b[9:0] = 10'($urandom);
      if (i % 2 == 0) begin
        a[17:10] = 8'($urandom_range(1, 254));
        b[17:10] = 8'($urandom_range(1, 254));
      end else begin
        a[17:10] = 8'($urandom_range(110, 144));
        b[17:10] = 8'($urandom_range(110, 144));
      end
      run_op(a, b, r, dz, lat);
      chk($sformatf("rand %0h/%0h", a, b), 32'(r), 32'(ref_div(a, b)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
